// File: rtl/vga_timing_pattern_pkg.sv
// Shared VGA timing defaults (640x480@60), pattern mode codes and colour helpers.
// Other resolutions reuse this package and override the timing parameters.
package vga_timing_pattern_pkg;

  localparam int unsigned VGA640_H_VISIBLE     = 640;
  localparam int unsigned VGA640_H_FRONT_PORCH = 16;
  localparam int unsigned VGA640_H_SYNC_PULSE  = 96;
  localparam int unsigned VGA640_H_BACK_PORCH  = 48;
  localparam int unsigned VGA640_V_VISIBLE     = 480;
  localparam int unsigned VGA640_V_FRONT_PORCH = 10;
  localparam int unsigned VGA640_V_SYNC_PULSE  = 2;
  localparam int unsigned VGA640_V_BACK_PORCH  = 33;
  localparam bit          VGA640_H_SYNC_POL    = 1'b0;
  localparam bit          VGA640_V_SYNC_POL    = 1'b0;

  localparam int unsigned DEFAULT_COLOR_BITS = 8;
  localparam int unsigned DEFAULT_BITS_X     = 10;
  localparam int unsigned DEFAULT_BITS_Y     = 10;
  localparam int unsigned FRAME_COUNT_W      = 8;

  localparam int unsigned BAR_COUNT = 8;
  localparam int unsigned BAR_IDX_W = 4;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_CHECKER  = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_STRIPES  = 2'd3
  } pattern_mode_e;

  // Per-channel full-scale enables for the flat-colour patterns
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_mask_t;

  // Colour bar order; index BAR_COUNT and above covers the black remainder
  function automatic rgb_mask_t bar_color(input logic [BAR_IDX_W-1:0] idx);
    rgb_mask_t c;
    c = rgb_mask_t'(3'b000);
    case (idx)
      4'd0:    c = rgb_mask_t'(3'b111);
      4'd1:    c = rgb_mask_t'(3'b110);
      4'd2:    c = rgb_mask_t'(3'b011);
      4'd3:    c = rgb_mask_t'(3'b010);
      4'd4:    c = rgb_mask_t'(3'b101);
      4'd5:    c = rgb_mask_t'(3'b100);
      4'd6:    c = rgb_mask_t'(3'b001);
      default: c = rgb_mask_t'(3'b000);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_pattern_sync_counter.sv
// Beam position counters plus combinational blank/sync decode of the current position.
// Consumers register the _c outputs so everything leaves aligned with the position.
module vga_sync_counter
  import vga_timing_pattern_pkg::*;
#(
  parameter int unsigned C_h_visible       = VGA640_H_VISIBLE,
  parameter int unsigned C_h_front_porch   = VGA640_H_FRONT_PORCH,
  parameter int unsigned C_h_sync_pulse    = VGA640_H_SYNC_PULSE,
  parameter int unsigned C_h_back_porch    = VGA640_H_BACK_PORCH,
  parameter int unsigned C_v_visible       = VGA640_V_VISIBLE,
  parameter int unsigned C_v_front_porch   = VGA640_V_FRONT_PORCH,
  parameter int unsigned C_v_sync_pulse    = VGA640_V_SYNC_PULSE,
  parameter int unsigned C_v_back_porch    = VGA640_V_BACK_PORCH,
  parameter bit          C_h_sync_polarity = VGA640_H_SYNC_POL,
  parameter bit          C_v_sync_polarity = VGA640_V_SYNC_POL,
  parameter int unsigned C_bits_x          = DEFAULT_BITS_X,
  parameter int unsigned C_bits_y          = DEFAULT_BITS_Y
) (
  input  logic                i_clk,
  input  logic                i_reset,
  output logic [C_bits_x-1:0] o_x,
  output logic [C_bits_y-1:0] o_y,
  output logic                o_x_last_c,
  output logic                o_frame_first_c,
  output logic                o_blank_c,
  output logic                o_hsync_c,
  output logic                o_vsync_c
);

  localparam int unsigned H_TOTAL  = C_h_visible + C_h_front_porch + C_h_sync_pulse + C_h_back_porch;
  localparam int unsigned V_TOTAL  = C_v_visible + C_v_front_porch + C_v_sync_pulse + C_v_back_porch;
  localparam int unsigned HS_START = C_h_visible + C_h_front_porch;
  localparam int unsigned HS_END   = HS_START + C_h_sync_pulse;
  localparam int unsigned VS_START = C_v_visible + C_v_front_porch;
  localparam int unsigned VS_END   = VS_START + C_v_sync_pulse;

  logic [C_bits_x-1:0] r_x;
  logic [C_bits_y-1:0] r_y;
  logic                w_x_last;
  logic                w_y_last;
  logic                w_hs_active;
  logic                w_vs_active;

  assign w_x_last = (r_x == C_bits_x'(H_TOTAL - 1));
  assign w_y_last = (r_y == C_bits_y'(V_TOTAL - 1));

  // Raster scan: x every pixel, y only on x wrap
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_x_last) begin
      r_x <= '0;
      r_y <= w_y_last ? '0 : r_y + C_bits_y'(1);
    end else begin
      r_x <= r_x + C_bits_x'(1);
    end
  end

  assign w_hs_active = (r_x >= C_bits_x'(HS_START)) && (r_x < C_bits_x'(HS_END));
  assign w_vs_active = (r_y >= C_bits_y'(VS_START)) && (r_y < C_bits_y'(VS_END));

  assign o_x             = r_x;
  assign o_y             = r_y;
  assign o_x_last_c      = w_x_last;
  assign o_frame_first_c = (r_x == '0) && (r_y == '0);
  assign o_blank_c       = (r_x >= C_bits_x'(C_h_visible)) || (r_y >= C_bits_y'(C_v_visible));
  assign o_hsync_c       = w_hs_active ? C_h_sync_polarity : ~C_h_sync_polarity;
  assign o_vsync_c       = w_vs_active ? C_v_sync_polarity : ~C_v_sync_polarity;

endmodule

// File: rtl/vga_timing_pattern.sv
// VGA timing generator with built-in test patterns; every output is registered
// one cycle after the beam counter state so position, syncs and colour stay aligned.
module vga_timing_pattern
  import vga_timing_pattern_pkg::*;
#(
  parameter int unsigned C_h_visible       = VGA640_H_VISIBLE,
  parameter int unsigned C_h_front_porch   = VGA640_H_FRONT_PORCH,
  parameter int unsigned C_h_sync_pulse    = VGA640_H_SYNC_PULSE,
  parameter int unsigned C_h_back_porch    = VGA640_H_BACK_PORCH,
  parameter int unsigned C_v_visible       = VGA640_V_VISIBLE,
  parameter int unsigned C_v_front_porch   = VGA640_V_FRONT_PORCH,
  parameter int unsigned C_v_sync_pulse    = VGA640_V_SYNC_PULSE,
  parameter int unsigned C_v_back_porch    = VGA640_V_BACK_PORCH,
  parameter bit          C_h_sync_polarity = VGA640_H_SYNC_POL,
  parameter bit          C_v_sync_polarity = VGA640_V_SYNC_POL,
  parameter int unsigned C_color_bits      = DEFAULT_COLOR_BITS,
  parameter int unsigned C_bits_x          = DEFAULT_BITS_X,
  parameter int unsigned C_bits_y          = DEFAULT_BITS_Y
) (
  input  logic                     clk_pixel,
  input  logic                     reset,
  input  logic                     test_picture,
  input  logic [1:0]               pattern_mode,
  output logic [C_color_bits-1:0]  vga_r,
  output logic [C_color_bits-1:0]  vga_g,
  output logic [C_color_bits-1:0]  vga_b,
  output logic                     vga_hsync,
  output logic                     vga_vsync,
  output logic                     vga_blank,
  output logic [C_bits_x-1:0]      beam_x,
  output logic [C_bits_y-1:0]      beam_y,
  output logic                     frame_start,
  output logic [FRAME_COUNT_W-1:0] frame_count
);

  localparam int unsigned BAR_W = C_h_visible / BAR_COUNT;

  logic [C_bits_x-1:0]      w_x;
  logic [C_bits_y-1:0]      w_y;
  logic                     w_x_last;
  logic                     w_frame_first;
  logic                     w_blank;
  logic                     w_hsync;
  logic                     w_vsync;

  pattern_mode_e            r_mode;
  pattern_mode_e            w_mode;
  logic [C_bits_x-1:0]      r_bar_pix;
  logic [BAR_IDX_W-1:0]     r_bar_idx;
  logic                     r_started;
  logic [FRAME_COUNT_W-1:0] w_fc_next;
  logic [5:0]               w_stripe_sum;
  logic                     w_stripe_on;
  rgb_mask_t                w_mask;
  logic [C_color_bits-1:0]  w_r;
  logic [C_color_bits-1:0]  w_g;
  logic [C_color_bits-1:0]  w_b;

  logic [C_color_bits-1:0]  r_r;
  logic [C_color_bits-1:0]  r_g;
  logic [C_color_bits-1:0]  r_b;
  logic                     r_hsync;
  logic                     r_vsync;
  logic                     r_blank;
  logic [C_bits_x-1:0]      r_beam_x;
  logic [C_bits_y-1:0]      r_beam_y;
  logic                     r_frame_start;
  logic [FRAME_COUNT_W-1:0] r_frame_count;

  vga_sync_counter #(
    .C_h_visible       (C_h_visible),
    .C_h_front_porch   (C_h_front_porch),
    .C_h_sync_pulse    (C_h_sync_pulse),
    .C_h_back_porch    (C_h_back_porch),
    .C_v_visible       (C_v_visible),
    .C_v_front_porch   (C_v_front_porch),
    .C_v_sync_pulse    (C_v_sync_pulse),
    .C_v_back_porch    (C_v_back_porch),
    .C_h_sync_polarity (C_h_sync_polarity),
    .C_v_sync_polarity (C_v_sync_polarity),
    .C_bits_x          (C_bits_x),
    .C_bits_y          (C_bits_y)
  ) u_sync_counter (
    .i_clk           (clk_pixel),
    .i_reset         (reset),
    .o_x             (w_x),
    .o_y             (w_y),
    .o_x_last_c      (w_x_last),
    .o_frame_first_c (w_frame_first),
    .o_blank_c       (w_blank),
    .o_hsync_c       (w_hsync),
    .o_vsync_c       (w_vsync)
  );

  // Mode is captured at pixel (0,0) and applies to that pixel and the rest of the frame
  assign w_mode = w_frame_first ? pattern_mode_e'(pattern_mode) : r_mode;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_mode <= PAT_BARS;
    end else if (w_frame_first) begin
      r_mode <= pattern_mode_e'(pattern_mode);
    end
  end

  // Bar index tracks the counter x without a divider; saturates on the black remainder
  always_ff @(posedge clk_pixel) begin
    if (reset || w_x_last) begin
      r_bar_pix <= '0;
      r_bar_idx <= '0;
    end else if (r_bar_pix == C_bits_x'(BAR_W - 1)) begin
      r_bar_pix <= '0;
      if (r_bar_idx != BAR_IDX_W'(BAR_COUNT)) begin
        r_bar_idx <= r_bar_idx + BAR_IDX_W'(1);
      end
    end else begin
      r_bar_pix <= r_bar_pix + C_bits_x'(1);
    end
  end

  // The frame_start right after reset opens frame 0, so it does not count a completed frame
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_started <= 1'b0;
    end else if (w_frame_first) begin
      r_started <= 1'b1;
    end
  end

  assign w_fc_next = (w_frame_first && r_started) ? r_frame_count + FRAME_COUNT_W'(1) : r_frame_count;

  // Bit 5 of the full-width sum depends only on the low six bits of each operand
  assign w_stripe_sum = 6'(w_x) + 6'(w_y) + 6'(w_fc_next);
  assign w_stripe_on  = (w_stripe_sum >= 6'd32);

  always_comb begin
    w_mask = rgb_mask_t'(3'b000);
    case (w_mode)
      PAT_BARS:    w_mask = bar_color(r_bar_idx);
      PAT_CHECKER: w_mask = rgb_mask_t'({3{w_x[5] ^ w_y[5]}});
      PAT_STRIPES: w_mask = rgb_mask_t'({3{w_stripe_on}});
      default:     w_mask = rgb_mask_t'(3'b000);
    endcase
  end

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (test_picture && !w_blank) begin
      if (w_mode == PAT_GRADIENT) begin
        w_r = C_color_bits'(w_x);
        w_g = C_color_bits'(w_x);
        w_b = C_color_bits'(w_x);
      end else begin
        w_r = {C_color_bits{w_mask.r}};
        w_g = {C_color_bits{w_mask.g}};
        w_b = {C_color_bits{w_mask.b}};
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_r           <= '0;
      r_g           <= '0;
      r_b           <= '0;
      r_hsync       <= ~C_h_sync_polarity;
      r_vsync       <= ~C_v_sync_polarity;
      r_blank       <= 1'b1;
      r_beam_x      <= '0;
      r_beam_y      <= '0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_r           <= w_r;
      r_g           <= w_g;
      r_b           <= w_b;
      r_hsync       <= w_hsync;
      r_vsync       <= w_vsync;
      r_blank       <= w_blank;
      r_beam_x      <= w_x;
      r_beam_y      <= w_y;
      r_frame_start <= w_frame_first;
      r_frame_count <= w_fc_next;
    end
  end

  assign vga_r       = r_r;
  assign vga_g       = r_g;
  assign vga_b       = r_b;
  assign vga_hsync   = r_hsync;
  assign vga_vsync   = r_vsync;
  assign vga_blank   = r_blank;
  assign beam_x      = r_beam_x;
  assign beam_y      = r_beam_y;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_pattern.sv
// Directed bench: default 640x480 line timing, 800x600 high-polarity timing,
// a reduced raster for full-frame pattern/mode/reset behaviour, and a tiny raster for frame_count wrap.
module tb_vga_timing_pattern;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // d_: default 640x480, s_: 800x600, m_: 80x56 raster, t_: 16x8 raster
  logic       d_rst, d_tp, d_hs, d_vs, d_bl, d_fs;
  logic [1:0] d_mode;
  logic [7:0] d_r, d_g, d_b, d_fc;
  logic [9:0] d_x, d_y;

  logic        s_rst, s_tp, s_hs, s_vs, s_bl, s_fs;
  logic [1:0]  s_mode;
  logic [7:0]  s_r, s_g, s_b, s_fc;
  logic [10:0] s_x;
  logic [9:0]  s_y;

  logic       m_rst, m_tp, m_hs, m_vs, m_bl, m_fs;
  logic [1:0] m_mode;
  logic [7:0] m_r, m_g, m_b, m_fc;
  logic [9:0] m_x, m_y;

  logic       t_rst, t_tp, t_hs, t_vs, t_bl, t_fs;
  logic [1:0] t_mode;
  logic [7:0] t_r, t_g, t_b, t_fc;
  logic [9:0] t_x, t_y;

  vga_timing_pattern u_def (
    .clk_pixel(clk), .reset(d_rst), .test_picture(d_tp), .pattern_mode(d_mode),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .vga_hsync(d_hs), .vga_vsync(d_vs),
    .vga_blank(d_bl), .beam_x(d_x), .beam_y(d_y), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_pattern #(
    .C_h_visible(800), .C_h_front_porch(40), .C_h_sync_pulse(128), .C_h_back_porch(88),
    .C_v_visible(600), .C_v_front_porch(1), .C_v_sync_pulse(4), .C_v_back_porch(23),
    .C_h_sync_polarity(1'b1), .C_v_sync_polarity(1'b1), .C_color_bits(8),
    .C_bits_x(11), .C_bits_y(10)
  ) u_svga (
    .clk_pixel(clk), .reset(s_rst), .test_picture(s_tp), .pattern_mode(s_mode),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hsync(s_hs), .vga_vsync(s_vs),
    .vga_blank(s_bl), .beam_x(s_x), .beam_y(s_y), .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_timing_pattern #(
    .C_h_visible(64), .C_h_front_porch(4), .C_h_sync_pulse(8), .C_h_back_porch(4),
    .C_v_visible(48), .C_v_front_porch(2), .C_v_sync_pulse(2), .C_v_back_porch(4)
  ) u_small (
    .clk_pixel(clk), .reset(m_rst), .test_picture(m_tp), .pattern_mode(m_mode),
    .vga_r(m_r), .vga_g(m_g), .vga_b(m_b), .vga_hsync(m_hs), .vga_vsync(m_vs),
    .vga_blank(m_bl), .beam_x(m_x), .beam_y(m_y), .frame_start(m_fs), .frame_count(m_fc)
  );

  vga_timing_pattern #(
    .C_h_visible(8), .C_h_front_porch(2), .C_h_sync_pulse(4), .C_h_back_porch(2),
    .C_v_visible(4), .C_v_front_porch(1), .C_v_sync_pulse(1), .C_v_back_porch(2)
  ) u_tiny (
    .clk_pixel(clk), .reset(t_rst), .test_picture(t_tp), .pattern_mode(t_mode),
    .vga_r(t_r), .vga_g(t_g), .vga_b(t_b), .vga_hsync(t_hs), .vga_vsync(t_vs),
    .vga_blank(t_bl), .beam_x(t_x), .beam_y(t_y), .frame_start(t_fs), .frame_count(t_fc)
  );

  localparam int M_HT = 80;
  localparam int M_FT = 80 * 56;
  localparam int T_FT = 16 * 8;
  localparam int MAIN_CYC = 256 * T_FT + 16;

  int  m_lat = 0;
  bit  sched_on = 1'b1;

  task automatic check(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] exp_rgb(input int x, input int y, input int hv, input int vv,
                                          input int mode, input bit tp, input int fc);
    logic [2:0] m;
    int s;
    m = 3'b000;
    if (!tp || x >= hv || y >= vv) return 64'd0;
    case (mode)
      0: case (x / (hv / 8))
           0: m = 3'b111;  1: m = 3'b110;  2: m = 3'b011;  3: m = 3'b010;
           4: m = 3'b101;  5: m = 3'b100;  6: m = 3'b001;  default: m = 3'b000;
         endcase
      1: m = {3{x[5] ^ y[5]}};
      2: return 64'({3{8'(x)}});
      default: begin
        s = x + y + fc;
        m = {3{s[5]}};
      end
    endcase
    return 64'({{8{m[2]}}, {8{m[1]}}, {8{m[0]}}});
  endfunction

  // {blank, hsync, vsync, frame_start}
  function automatic logic [63:0] exp_ctrl(input int x, input int y, input int hv, input int hf, input int hw,
                                           input int vv, input int vf, input int vw, input bit hp, input bit vp);
    bit bl, ha, va, fs;
    bl = (x >= hv) || (y >= vv);
    ha = (x >= hv + hf) && (x < hv + hf + hw);
    va = (y >= vv + vf) && (y < vv + vf + vw);
    fs = (x == 0) && (y == 0);
    return 64'({bl, ha ? hp : !hp, va ? vp : !vp, fs});
  endfunction

  // Mode schedule for the reduced raster plus the bench's own copy of the latched mode
  task automatic small_drive(input int p);
    int x, y, f;
    x = p % M_HT;
    y = (p % M_FT) / M_HT;
    f = p / M_FT;
    if (sched_on) begin
      if (x == 0 && y == 10) begin
        case (f)
          0: m_mode = 2'd1;
          1: m_mode = 2'd3;
          2: m_mode = 2'd2;
          3: m_mode = 2'd0;
          default: ;
        endcase
      end
      if (f == 4 && x == 0 && y == 30) m_tp = 1'b0;
      if (f == 5 && x == 40 && y == 0) m_tp = 1'b1;
    end
    if (x == 0 && y == 0) m_lat = int'(m_mode);
  endtask

  task automatic small_check(input int p, input int fc);
    int x, y;
    x = p % M_HT;
    y = (p % M_FT) / M_HT;
    check("small_rgb", p, 64'({m_r, m_g, m_b}), exp_rgb(x, y, 64, 48, m_lat, m_tp, fc));
    check("small_ctrl", p, 64'({m_bl, m_hs, m_vs, m_fs}), exp_ctrl(x, y, 64, 4, 8, 48, 2, 2, 1'b0, 1'b0));
    check("small_pos", p, 64'({m_x, m_y, m_fc}), 64'({10'(x), 10'(y), 8'(fc)}));
  endtask

  initial begin
    int c, p;
    int d_hs_low, d_hs_first, s_hs_high, s_hs_first, m_vs_lines, m_vs_first, m_fs_cnt;
    int fs_first, fs_second;
    d_hs_low = 0; d_hs_first = -1; s_hs_high = 0; s_hs_first = -1;
    m_vs_lines = 0; m_vs_first = -1; m_fs_cnt = 0; fs_first = -1; fs_second = -1;

    d_rst = 1'b1; d_tp = 1'b1; d_mode = 2'd0;
    s_rst = 1'b1; s_tp = 1'b0; s_mode = 2'd2;
    m_rst = 1'b1; m_tp = 1'b1; m_mode = 2'd0;
    t_rst = 1'b1; t_tp = 1'b1; t_mode = 2'd0;

    for (int i = 0; i < 3; i++) begin
      step();
      check("def_reset_rgb", i, 64'({d_r, d_g, d_b}), 64'd0);
      check("def_reset_ctrl", i, 64'({d_bl, d_hs, d_vs, d_fs}), 64'b1110);
      check("def_reset_pos", i, 64'({d_x, d_y, d_fc}), 64'd0);
      check("svga_reset_ctrl", i, 64'({s_bl, s_hs, s_vs, s_fs}), 64'b1000);
      check("small_reset_ctrl", i, 64'({m_bl, m_hs, m_vs, m_fs}), 64'b1110);
    end

    d_rst = 1'b0; s_rst = 1'b0; m_rst = 1'b0; t_rst = 1'b0;

    for (c = 0; c < MAIN_CYC; c++) begin
      small_drive(c);
      step();
      small_check(c, (c / M_FT) % 256);

      if (c < 1600) begin
        check("def_rgb", c, 64'({d_r, d_g, d_b}), exp_rgb(c % 800, c / 800, 640, 480, 0, 1'b1, 0));
        check("def_ctrl", c, 64'({d_bl, d_hs, d_vs, d_fs}),
              exp_ctrl(c % 800, c / 800, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0));
        check("def_pos", c, 64'({d_x, d_y, d_fc}), 64'({10'(c % 800), 10'(c / 800), 8'd0}));
        check("svga_rgb", c, 64'({s_r, s_g, s_b}), 64'd0);
        check("svga_ctrl", c, 64'({s_bl, s_hs, s_vs, s_fs}),
              exp_ctrl(c % 1056, c / 1056, 800, 40, 128, 600, 1, 4, 1'b1, 1'b1));
        check("svga_pos", c, 64'({s_x, s_y, s_fc}), 64'({11'(c % 1056), 10'(c / 1056), 8'd0}));
      end
      if (c < 800 && d_hs == 1'b0) begin
        d_hs_low++;
        if (d_hs_first < 0) d_hs_first = int'(d_x);
      end
      if (c < 1056 && s_hs == 1'b1) begin
        s_hs_high++;
        if (s_hs_first < 0) s_hs_first = int'(s_x);
      end
      if (c < M_FT && m_x == 10'd0 && m_vs == 1'b0) begin
        m_vs_lines++;
        if (m_vs_first < 0) m_vs_first = int'(m_y);
      end
      if (m_fs == 1'b1) begin
        if (fs_first < 0) fs_first = c;
        else if (fs_second < 0) fs_second = c;
      end

      check("tiny_rgb", c, 64'({t_r, t_g, t_b}), exp_rgb(c % 16, (c % T_FT) / 16, 8, 4, 0, 1'b1, 0));
      check("tiny_ctrl", c, 64'({t_bl, t_hs, t_vs, t_fs}),
            exp_ctrl(c % 16, (c % T_FT) / 16, 8, 2, 4, 4, 1, 1, 1'b0, 1'b0));
      check("tiny_pos", c, 64'({t_x, t_y, t_fc}),
            64'({10'(c % 16), 10'((c % T_FT) / 16), 8'((c / T_FT) % 256)}));
      if (c == 255 * T_FT) check("tiny_fc_255", c, 64'(t_fc), 64'd255);
      if (c == 256 * T_FT) check("tiny_fc_wrap", c, 64'({t_fs, t_fc}), 64'({1'b1, 8'd0}));
    end

    check("def_hsync_len", c, 64'(d_hs_low), 64'd96);
    check("def_hsync_start", c, 64'(d_hs_first), 64'd656);
    check("svga_hsync_len", c, 64'(s_hs_high), 64'd128);
    check("svga_hsync_start", c, 64'(s_hs_first), 64'd840);
    check("small_vsync_lines", c, 64'(m_vs_lines), 64'd2);
    check("small_vsync_start", c, 64'(m_vs_first), 64'd50);
    check("small_frame_period", c, 64'(fs_second - fs_first), 64'(M_FT));

    // Run the reduced raster up to (30,20), then reset it mid-frame
    sched_on = 1'b0;
    while ((c % M_FT) != 20 * M_HT + 30) begin
      small_drive(c);
      step();
      small_check(c, (c / M_FT) % 256);
      c++;
    end
    m_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("small_rst_rgb", i, 64'({m_r, m_g, m_b}), 64'd0);
      check("small_rst_ctrl", i, 64'({m_bl, m_hs, m_vs, m_fs}), 64'b1110);
      check("small_rst_pos", i, 64'({m_x, m_y, m_fc}), 64'd0);
    end
    m_rst = 1'b0;
    for (p = 0; p <= M_FT; p++) begin
      small_drive(p);
      step();
      small_check(p, p / M_FT);
      if (p < M_FT && m_fs == 1'b1) m_fs_cnt++;
    end
    check("small_fs_after_reset", p, 64'(m_fs_cnt), 64'd1);
    check("small_fc_after_reset", p, 64'({m_fs, m_fc}), 64'({1'b1, 8'd1}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
